// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier (low 32 bits of a*b) that borrows the shared
// execute-stage ALU: every iteration issues ADD, SLL and SRL and captures the result.
module alu_mul_sequencer #(
  parameter int         ITERATIONS = 32,
  parameter logic [3:0] ALU_ADD    = 4'b0011,
  parameter logic [3:0] ALU_SLL    = 4'b0010,
  parameter logic [3:0] ALU_SRL    = 4'b0100,
  parameter logic [3:0] ALU_IDLE   = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o,
  output logic [3:0]  alu_operation_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  alu_shamt_o,
  input  logic [31:0] alu_data_i
);

  localparam int            CW         = $clog2(ITERATIONS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITERATIONS - 1);

  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} state_t;

  state_t         state, state_next;
  logic [31:0]    acc, mcand, mplier, product_q;
  logic [CW-1:0]  count;
  logic           last_iter;

  assign last_iter = (count == LAST_COUNT);
  assign product_o = product_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The ADD phase is issued even when mplier[0]=0 so the latency never depends on the operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          mcand  <= a_i;
          mplier <= b_i;
          acc    <= '0;
          count  <= '0;
        end
        ADD: if (mplier[0]) acc <= alu_data_i;
        SHL: mcand <= alu_data_i;
        SHR: begin
          mplier <= alu_data_i;
          count  <= count + CW'(1);
          if (last_iter) product_q <= acc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next      = state;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    alu_operation_o = ALU_IDLE;
    alu_a_o         = '0;
    alu_b_o         = '0;
    alu_shamt_o     = '0;
    case (state)
      IDLE: if (start_i) state_next = ADD;
      ADD: begin
        busy_o          = 1'b1;
        alu_operation_o = ALU_ADD;
        alu_a_o         = acc;
        alu_b_o         = mcand;
        state_next      = SHL;
      end
      SHL: begin
        busy_o          = 1'b1;
        alu_operation_o = ALU_SLL;
        alu_b_o         = mcand;
        alu_shamt_o     = 5'd1;
        state_next      = SHR;
      end
      SHR: begin
        busy_o          = 1'b1;
        alu_operation_o = ALU_SRL;
        alu_b_o         = mplier;
        alu_shamt_o     = 5'd1;
        state_next      = last_iter ? DONE : ADD;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU closes the loop, products are
// compared against plain a*b, and latency/op ordering is tracked cycle by cycle.
module tb_alu_mul_sequencer;

  localparam int         IT       = 32;
  localparam int         IT8      = 8;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_IDLE  = 4'b1111;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
    bit          noise;
    string       name;
  } vec_t;

  logic        clk, reset;
  logic        start, busy, done;
  logic [31:0] a, b, product, alu_a, alu_b, alu_data;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;

  logic        start8, busy8, done8;
  logic [31:0] a8, b8, product8, alu_a8, alu_b8, alu_data8;
  logic [3:0]  alu_op8;
  logic [4:0]  alu_shamt8;

  int          vectors_applied;
  int          miscompares;
  logic [31:0] prev_product;

  alu_mul_sequencer #(.ITERATIONS(IT)) u_dut (
    .clk(clk), .reset(reset), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .product_o(product),
    .alu_operation_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_shamt_o(alu_shamt), .alu_data_i(alu_data)
  );

  alu_mul_sequencer #(.ITERATIONS(IT8)) u_dut8 (
    .clk(clk), .reset(reset), .start_i(start8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .product_o(product8),
    .alu_operation_o(alu_op8), .alu_a_o(alu_a8), .alu_b_o(alu_b8),
    .alu_shamt_o(alu_shamt8), .alu_data_i(alu_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the shared ALU that the sequencer drives.
  function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [4:0] sh);
    case (op)
      OP_ADD:  return x + y;
      OP_SLL:  return y << sh;
      OP_SRL:  return y >> sh;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_data  = aluModel(alu_op, alu_a, alu_b, alu_shamt);
  assign alu_data8 = aluModel(alu_op8, alu_a8, alu_b8, alu_shamt8);

  function automatic logic [31:0] refMul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] full;
    full = 64'(x) * 64'(y);
    return full[31:0];
  endfunction

  function automatic logic [3:0] expectedOp(input int i);
    case (i % 3)
      0:       return OP_ADD;
      1:       return OP_SLL;
      default: return OP_SRL;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Returns at the falling edge just after the accepting clock edge (cycle 0 of the op).
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows an accepted op from cycle 0 through the done pulse and back to idle.
  task automatic trackOp(input logic [31:0] expected, input string name, input bit noise);
    int seq_errors;
    seq_errors = 0;
    for (int i = 0; i < 3 * IT; i++) begin
      if (i > 0) @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || alu_op !== expectedOp(i)) seq_errors++;
      if (i == 3 * IT - 1) checkOutput({name, " product held"}, product, prev_product);
      if (noise) begin
        if (i == 10 || i == 50) begin
          start = 1'b1;
          a     = 32'd100;
          b     = 32'd100;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput({name, " busy/op seq errors"}, 32'(seq_errors), 32'd0);
    @(negedge clk);
    checkOutput({name, " done"}, 32'(done), 32'd1);
    checkOutput({name, " busy at done"}, 32'(busy), 32'd0);
    checkOutput({name, " product"}, product, expected);
    prev_product = expected;
    @(negedge clk);
    checkOutput({name, " done single pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   done_seen;
    int   busy_errors;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd7,         32'd6,         32'd42,        1'b0, "7x6"};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  1'b0, "max x max"};
    vecs[2] = '{32'h00010000,  32'h00010000,  32'h00000000,  1'b0, "wrap"};
    vecs[3] = '{32'h12345678,  32'd0,         32'd0,         1'b0, "b zero"};
    vecs[4] = '{32'd0,         32'hDEADBEEF,  32'd0,         1'b0, "a zero"};
    vecs[5] = '{32'd3,         32'd5,         32'd15,        1'b1, "ignore start"};

    vectors_applied = 0;
    miscompares     = 0;
    prev_product    = 32'd0;
    reset  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset product", product, 32'd0);
    checkOutput("reset alu op", 32'(alu_op), 32'(OP_IDLE));
    checkOutput("reset alu a/b/shamt", alu_a | alu_b | 32'(alu_shamt), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle without start", 32'({busy, done}), 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      trackOp(vecs[i].expected, vecs[i].name, vecs[i].noise);
    end

    // start held high from late in the op through DONE: only the idle-state sample counts.
    applyStimulus(32'd20, 32'd30);
    repeat (3 * IT - 2) @(negedge clk);
    start = 1'b1;
    a     = 32'd11;
    b     = 32'd13;
    @(negedge clk);
    @(negedge clk);
    checkOutput("held start first done", 32'(done), 32'd1);
    checkOutput("held start first product", product, refMul(32'd20, 32'd30));
    prev_product = refMul(32'd20, 32'd30);
    @(negedge clk);
    checkOutput("held start idle gap", 32'({busy, done}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    trackOp(refMul(32'd11, 32'd13), "held start second op", 1'b0);

    // Asynchronous abort in the middle of an op.
    applyStimulus(32'd50, 32'd60);
    repeat (39) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort product", product, 32'd0);
    checkOutput("abort alu op", 32'(alu_op), 32'(OP_IDLE));
    @(negedge clk);
    reset        = 1'b1;
    prev_product = 32'd0;
    done_seen    = 0;
    for (int i = 0; i < 3 * IT + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checkOutput("abort no activity", 32'(done_seen), 32'd0);
    applyStimulus(32'd9, 32'd9);
    trackOp(32'd81, "after abort 9x9", 1'b0);

    for (int n = 0; n < 500; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 1) rb = rb & 32'hFF;
      if (n % 7 == 2) ra = ra >> $urandom_range(31, 0);
      applyStimulus(ra, rb);
      trackOp(refMul(ra, rb), "random", 1'b0);
    end

    // Short build: only the low 8 multiplier bits are processed.
    @(negedge clk);
    start8 = 1'b1;
    a8     = 32'h01010101;
    b8     = 32'h000000FF;
    @(posedge clk);
    @(negedge clk);
    start8      = 1'b0;
    busy_errors = 0;
    for (int i = 0; i < 3 * IT8; i++) begin
      if (i > 0) @(negedge clk);
      if (busy8 !== 1'b1 || done8 !== 1'b0) busy_errors++;
    end
    checkOutput("it8 busy errors", 32'(busy_errors), 32'd0);
    @(negedge clk);
    checkOutput("it8 done at start+24", 32'(done8), 32'd1);
    checkOutput("it8 product", product8, refMul(32'h01010101, 32'h000000FF));
    @(negedge clk);
    checkOutput("it8 done single pulse", 32'(done8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 32-bit unsigned multiply (low 32 bits of a*b) using only the shared combinational ALU's ADD, SLL and SRL operations.
- Drives the ALU operation, operand and shamt inputs each cycle and captures the ALU result on the following clock edge.
- Sits beside the ALU in the execute stage. It serves MUL-type instructions without a dedicated multiplier array, and pipeline control stalls on busy_o.

Parameters:
- ITERATIONS, 32, number of multiplier bits processed (1..32); the product is correct for b_i < 2^ITERATIONS.
- ALU_ADD, 4'b0011, ALU add opcode.
- ALU_SLL, 4'b0010, ALU shift-left opcode (shifts the ALU b operand by shamt).
- ALU_SRL, 4'b0100, ALU shift-right-logical opcode (shifts the ALU b operand by shamt).
- ALU_IDLE, 4'b1111, unused opcode; the ALU outputs 0 for it.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  request pulse/level, sampled only in IDLE.
- a_i  in  32  multiplicand, sampled with start_i.
- b_i  in  32  multiplier, sampled with start_i.
- busy_o  out  1  high in ADD/SHL/SHR.
- done_o  out  1  one-cycle pulse in DONE.
- product_o  out  32  result; held until the next accepted start.
- alu_operation_o  out  4  to ALU operation select.
- alu_a_o  out  32  to ALU operand a.
- alu_b_o  out  32  to ALU operand b.
- alu_shamt_o  out  5  to ALU shamt.
- alu_data_i  in  32  from ALU result.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, acc=0, mcand=0, mplier=0, count=0, product_o=0, busy_o=0, done_o=0.
- Reset ALU drive: alu_operation_o=ALU_IDLE, alu_a_o=0, alu_b_o=0, alu_shamt_o=0.
- Reset mid-operation aborts the operation; no done_o and product_o=0.
- Internal registers: acc[31:0], mcand[31:0], mplier[31:0], count (clog2(ITERATIONS+1) bits).
- The ALU drive is a Moore function of state and registers:
  - IDLE/DONE: operation ALU_IDLE, a=0, b=0, shamt=0.
  - ADD: operation ALU_ADD, a=acc, b=mcand, shamt=0.
  - SHL: operation ALU_SLL, a=0, b=mcand, shamt=1.
  - SHR: operation ALU_SRL, a=0, b=mplier, shamt=1.
- IDLE:
  - If start_i=1, load mcand=a_i, mplier=b_i, acc=0, count=0, then go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - If mplier[0]=1, acc<=alu_data_i; otherwise acc holds.
  - The ADD phase is always issued, which gives a fixed latency.
  - Go to SHL.
- SHL: mcand<=alu_data_i, then go to SHR.
- SHR:
  - mplier<=alu_data_i and count<=count+1.
  - If count==ITERATIONS-1, go to DONE; otherwise go to ADD.
- DONE:
  - product_o<=acc on entry, i.e. registered on the SHR->DONE edge.
  - done_o=1 for exactly this cycle; then go to IDLE.
  - start_i is ignored in DONE.
- Latency:
  - Start sampled at edge k; done_o is high between edges k+3*ITERATIONS and k+3*ITERATIONS+1 (edges k+96..k+97 for default).
  - busy_o is high from edge k until edge k+3*ITERATIONS.
  - The next start can be accepted at edge k+3*ITERATIONS+2, once back in IDLE.
- start_i while busy_o=1 or in DONE is ignored; a_i and b_i changes mid-operation have no effect.
- Arithmetic:
  - All values are unsigned modulo 2^32, and overflow wraps silently.
  - The mcand shift discards bit 31; mplier SRL shifts in 0.
- product_o changes only on the SHR->DONE edge and at reset.
- There is no early termination, even when mplier==0.

Test Plan:
- a=7, b=6, start pulse → busy_o high 96 cycles, done_o single pulse at start+96, product_o=42, ALU op sequence ADD,SLL,SRL repeated 32 times.
- a=0xFFFFFFFF, b=0xFFFFFFFF → product_o=0x00000001; a=0x00010000, b=0x00010000 → product_o=0x00000000 (wrap).
- a=0x12345678, b=0 → product_o=0 with the same 96-cycle latency; a=0, b=0xDEADBEEF → 0.
- During an active op (a=3, b=5), assert start_i with a=100, b=100 at cycles 10 and 50 → ignored, product_o=15; hold start_i high through DONE → the second op starts only from IDLE, and its result matches the inputs sampled then.
- Assert reset=0 asynchronously mid-op at cycle 40 → busy_o, done_o, product_o=0 and alu_operation_o=4'b1111 immediately; no done pulse; a fresh op 9*9 after release gives 81.
- Random 500 operand pairs with ITERATIONS=32 versus reference (a*b)[31:0]; ITERATIONS=8 build: b=0xFF, a=0x01010101 → 0xFFFFFFFF, done at start+24.
